ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: word address width of the shared RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; byte-strobe width NB = DATA_WIDTH/8.
REQ-003 SHALL have port clk  in  1: single clock, all state on posedge.
REQ-004 SHALL have port resetn  in  1: synchronous, active-low reset.
REQ-005 SHALL have port m0_req  in  1: requester 0 (instruction side) request valid.
REQ-006 SHALL have port m0_wstrb  in  NB: requester 0 byte write strobes; all-zero = read.
REQ-007 SHALL have port m0_addr  in  ADDR_WIDTH: requester 0 word address.
REQ-008 SHALL have port m0_wdata  in  DATA_WIDTH: requester 0 write data.
REQ-009 SHALL have port m0_addr_ok  out  1: requester 0 request accepted this cycle.
REQ-010 SHALL have port m0_data_ok  out  1: requester 0 response valid this cycle.
REQ-011 SHALL have ports m1_req, m1_wstrb, m1_addr, m1_wdata, m1_addr_ok, m1_data_ok: requester 1 (data side), same widths and meanings as m0_*.
REQ-012 SHALL have port rdata  out  DATA_WIDTH: read data shared by both requesters, qualified by mX_data_ok.
REQ-013 SHALL have port ram_en  out  1: RAM enable.
REQ-014 SHALL have port ram_we  out  NB: RAM byte write enables.
REQ-015 SHALL have port ram_addr  out  ADDR_WIDTH: RAM address.
REQ-016 SHALL have port ram_wdata  out  DATA_WIDTH: RAM write data.
REQ-017 SHALL have port ram_rdata  in  DATA_WIDTH: RAM read data, valid one cycle after ram_en with ram_we == 0.

Function
REQ-018 SHALL grant at most one requester per cycle; grant is combinational from mX_req and priority state; mX_addr_ok = grant to X.
REQ-019 SHALL accept a new request every cycle (fully pipelined, no idle bubble between back-to-back grants).
REQ-020 SHALL drive ram_en = 1, ram_we = granted wstrb, ram_addr/ram_wdata = granted addr/wdata in the grant cycle; ram_en = 0 and ram_we = 0 when no grant.
REQ-021 SHALL arbitrate round-robin: single-requester cycles grant that requester; when both request, grant the one not granted most recently; priority pointer updates only on a grant.
REQ-022 SHALL register resp_valid and resp_owner on each grant; mX_data_ok SHALL assert exactly one cycle after mX_addr_ok, for reads and writes.
REQ-023 SHALL drive rdata = ram_rdata combinationally; value is defined only for read responses, don't-care for write responses.
REQ-024 SHALL never assert m0_data_ok and m1_data_ok in the same cycle.
REQ-025 Requesters SHALL hold req/wstrb/addr/wdata stable until addr_ok; the arbiter SHALL not require req to drop between requests.
REQ-026 SHALL bound waiting: a continuously asserted request is granted within 2 cycles.
REQ-027 Same-address write then read in consecutive cycles SHALL return the written data (RAM ordering preserved).

Reset
REQ-028 On resetn == 0 at posedge: resp_valid = 0, priority pointer = m0 preferred; mX_addr_ok, mX_data_ok, ram_en, ram_we SHALL be 0 while resetn == 0.
REQ-029 Reset mid-operation SHALL discard an outstanding response: no data_ok in the cycle after reset deasserts.

Structure
REQ-030 SHALL place NB derivation and requester index constants (REQ_INST = 0, REQ_DATA = 1) in the shared package.
REQ-031 SHALL contain one sub-module, rr_arb2 (2-way round-robin grant plus pointer register); the response pipeline stays in ram_arbiter.

Verification
REQ-032 m0 read addr 0x0010 only -> m0_addr_ok cycle N, ram_addr = 0x0010, m0_data_ok cycle N+1, rdata = RAM[0x0010].
REQ-033 m0 and m1 both requesting continuously from reset -> grants alternate m0, m1, m0, m1; data_ok alternates one cycle later.
REQ-034 m1 write 0xDEADBEEF, wstrb 4'b0011, addr 0x0020, then m1 read 0x0020 next cycle -> rdata = old[31:16] concatenated with 0xBEEF.
REQ-035 m0 held, m1 requesting every cycle -> m0 granted within 2 cycles.
REQ-036 resetn low in the cycle after a grant -> no data_ok, ram_en = 0; first post-reset dual request is granted to m0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared constants and helpers for the two-requester RAM arbiter
package ram_arbiter_pkg;

    // Requester indices into grant/request vectors.
    localparam int REQ_INST = 0;
    localparam int REQ_DATA = 1;

    // Byte-strobe width for a given data width.
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rtl/ram_arbiter_rr_arb2.sv - two-way round-robin grant with last-granted pointer
//
// Ports:
//   clk    : clock, state on posedge
//   resetn : synchronous active-low reset; forces grant to zero while low
//   req    : request vector, index REQ_INST / REQ_DATA
//   gnt    : one-hot (or zero) combinational grant
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the requester granted most recently. Resetting it to the data
    // side makes the instruction side the preferred winner of the first tie.
    logic last_data;

    always_comb begin
        gnt = 2'b00;
        if (resetn) begin
            if (req[REQ_INST] && req[REQ_DATA]) begin
                gnt[REQ_INST] = last_data;
                gnt[REQ_DATA] = !last_data;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_data <= 1'b1;
        end else if (gnt[REQ_DATA]) begin
            last_data <= 1'b1;
        end else if (gnt[REQ_INST]) begin
            last_data <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - fully pipelined round-robin arbiter sharing one single-port RAM
//
// Ports:
//   clk, resetn                : clock and synchronous active-low reset
//   m0_* (instruction side)    : req, wstrb (all-zero = read), addr, wdata in;
//                                addr_ok (accepted), data_ok (response) out
//   m1_* (data side)           : same as m0_*
//   rdata                      : shared read data, qualified by mX_data_ok
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata       : RAM port; read data valid one cycle after ram_en
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    localparam int NB = strb_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_req,
    input  logic [NB-1:0]         m0_wstrb,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_addr_ok,
    output logic                  m0_data_ok,
    input  logic                  m1_req,
    input  logic [NB-1:0]         m1_wstrb,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_addr_ok,
    output logic                  m1_data_ok,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_en,
    output logic [NB-1:0]         ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel_data;
    logic       resp_valid;
    logic       resp_owner;

    assign req[REQ_INST] = m0_req;
    assign req[REQ_DATA] = m1_req;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .gnt    (gnt)
    );

    assign m0_addr_ok = gnt[REQ_INST];
    assign m1_addr_ok = gnt[REQ_DATA];
    assign sel_data   = gnt[REQ_DATA];

    // The granted request goes straight to the RAM in the grant cycle, so a
    // new request can be taken every cycle with no bubble.
    assign ram_en    = |gnt;
    assign ram_we    = !ram_en ? '0 : (sel_data ? m1_wstrb : m0_wstrb);
    assign ram_addr  = sel_data ? m1_addr  : m0_addr;
    assign ram_wdata = sel_data ? m1_wdata : m0_wdata;

    // One-deep response pipeline matching the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
        end else begin
            resp_valid <= |gnt;
            resp_owner <= sel_data;
        end
    end

    // Gated by resetn so no response is visible while reset is held.
    assign m0_data_ok = resetn && resp_valid && !resp_owner;
    assign m1_data_ok = resetn && resp_valid &&  resp_owner;
    assign rdata      = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - table-driven self-checking bench for ram_arbiter
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m1_req;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_req     (m0_req),
        .m0_wstrb   (m0_wstrb),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m1_req     (m1_req),
        .m1_wstrb   (m1_wstrb),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .rdata      (rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Behavioural RAM: mem[i] starts as 0xC0DE0000 | i.
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    typedef struct {
        logic        rstn;
        logic        r0; logic [3:0] s0; logic [15:0] a0; logic [31:0] d0;
        logic        r1; logic [3:0] s1; logic [15:0] a1; logic [31:0] d1;
        logic        ok0, ok1, dok0, dok1, en;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rstn,
                       input logic r0, input logic [3:0] s0, input logic [15:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] s1, input logic [15:0] a1, input logic [31:0] d1,
                       input logic ok0, input logic ok1, input logic dok0, input logic dok1,
                       input logic en, input logic [3:0] we, input logic [15:0] addr, input logic [31:0] wd,
                       input logic chk_rd, input logic [31:0] rd);
        vec_t v;
        v.rstn = rstn; v.r0 = r0; v.s0 = s0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.s1 = s1; v.a1 = a1; v.d1 = d1;
        v.ok0 = ok0; v.ok1 = ok1; v.dok0 = dok0; v.dok1 = dok1;
        v.en = en; v.we = we; v.addr = addr; v.wd = wd; v.chk_rd = chk_rd; v.rd = rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        resetn = v.rstn;
        m0_req = v.r0; m0_wstrb = v.s0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_wstrb = v.s1; m1_addr = v.a1; m1_wdata = v.d1;
    endtask

    int w0, w1;

    initial begin
        resetn = 1'b0;
        m0_req = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;

        //   rstn r0 s0 a0 d0            r1 s1 a1 d1                ok0 ok1 dk0 dk1 en we addr wd           chk rd
        // reset held with both requesting: everything quiet
        add(0, 1,0,16'h0001,0,           1,0,16'h0002,0,            0,0,0,0, 0,4'h0,16'h0000,0,          0,0);
        add(0, 1,0,16'h0001,0,           1,0,16'h0002,0,            0,0,0,0, 0,4'h0,16'h0000,0,          0,0);
        // m0 read 0x10 alone, response next cycle
        add(1, 1,0,16'h0010,0,           0,0,16'h0000,0,            1,0,0,0, 1,4'h0,16'h0010,0,          0,0);
        add(1, 0,0,16'h0000,0,           0,0,16'h0000,0,            0,0,1,0, 0,4'h0,16'h0000,0,          1,32'hC0DE0010);
        // m1 partial write then read of the same word
        add(1, 0,0,16'h0000,0,           1,4'h3,16'h0020,32'hDEADBEEF, 0,1,0,0, 1,4'h3,16'h0020,32'hDEADBEEF, 0,0);
        add(1, 0,0,16'h0000,0,           1,0,16'h0020,0,            0,1,0,1, 1,4'h0,16'h0020,0,          0,0);
        add(1, 0,0,16'h0000,0,           0,0,16'h0000,0,            0,0,0,1, 0,4'h0,16'h0000,0,          1,32'hC0DEBEEF);
        // m1 alone, then contention: m0 wins (m1 granted last), then alternation
        add(1, 0,0,16'h0000,0,           1,0,16'h0003,0,            0,1,0,0, 1,4'h0,16'h0003,0,          0,0);
        add(1, 1,0,16'h0004,0,           1,0,16'h0005,0,            1,0,0,1, 1,4'h0,16'h0004,0,          1,32'hC0DE0003);
        add(1, 1,0,16'h0006,0,           1,0,16'h0005,0,            0,1,1,0, 1,4'h0,16'h0005,0,          1,32'hC0DE0004);
        add(1, 1,0,16'h0006,0,           1,0,16'h0007,0,            1,0,0,1, 1,4'h0,16'h0006,0,          1,32'hC0DE0005);
        add(1, 0,0,16'h0000,0,           0,0,16'h0000,0,            0,0,1,0, 0,4'h0,16'h0000,0,          1,32'hC0DE0006);
        // grant to m0, then reset in the following cycle discards the response
        add(1, 1,0,16'h0008,0,           0,0,16'h0000,0,            1,0,0,0, 1,4'h0,16'h0008,0,          0,0);
        add(0, 1,0,16'h0009,0,           1,0,16'h000A,0,            0,0,0,0, 0,4'h0,16'h0000,0,          0,0);
        // first dual request after reset goes to m0, no stale data_ok
        add(1, 1,0,16'h0009,0,           1,0,16'h000A,0,            1,0,0,0, 1,4'h0,16'h0009,0,          0,0);
        add(1, 1,0,16'h000B,0,           1,0,16'h000A,0,            0,1,1,0, 1,4'h0,16'h000A,0,          1,32'hC0DE0009);
        add(1, 1,0,16'h000B,0,           1,0,16'h000C,0,            1,0,0,1, 1,4'h0,16'h000B,0,          1,32'hC0DE000A);
        add(1, 0,0,16'h0000,0,           0,0,16'h0000,0,            0,0,1,0, 0,4'h0,16'h0000,0,          1,32'hC0DE000B);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #4;
            chk("m0_addr_ok", i, 32'(m0_addr_ok), 32'(vecs[i].ok0));
            chk("m1_addr_ok", i, 32'(m1_addr_ok), 32'(vecs[i].ok1));
            chk("m0_data_ok", i, 32'(m0_data_ok), 32'(vecs[i].dok0));
            chk("m1_data_ok", i, 32'(m1_data_ok), 32'(vecs[i].dok1));
            chk("ram_en",     i, 32'(ram_en),     32'(vecs[i].en));
            chk("ram_we",     i, 32'(ram_we),     32'(vecs[i].we));
            if (vecs[i].en)          chk("ram_addr",  i, 32'(ram_addr), 32'(vecs[i].addr));
            if (vecs[i].we != 4'h0)  chk("ram_wdata", i, ram_wdata, vecs[i].wd);
            if (vecs[i].chk_rd)      chk("rdata",     i, rdata, vecs[i].rd);
            @(negedge clk);
        end

        // Continuous contention: each side waits at most one cycle, exactly
        // one grant per cycle, responses never collide.
        w0 = 0; w1 = 0;
        for (int c = 0; c < 16; c++) begin
            resetn = 1'b1;
            m0_req = 1'b1; m0_wstrb = 4'h0; m0_addr = 16'(c);
            m1_req = 1'b1; m1_wstrb = 4'h0; m1_addr = 16'(c + 32);
            #4;
            chk("one_grant", 100 + c, 32'(m0_addr_ok) + 32'(m1_addr_ok), 32'd1);
            chk("dok_excl",  100 + c, 32'(m0_data_ok && m1_data_ok), 32'd0);
            w0 = m0_addr_ok ? 0 : w0 + 1;
            w1 = m1_addr_ok ? 0 : w1 + 1;
            chk("m0_wait_bound", 100 + c, 32'(w0 > 1), 32'd0);
            chk("m1_wait_bound", 100 + c, 32'(w1 > 1), 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
